shift_sequencer: RTL and testbench



---
 rtl/shift_sequencer.sv | 134 +++++++++++++
 tb/tb_shift_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// Multi-cycle shift controller: one single-bit shift per clock until the amount is used up.
// Optional SHSEQ_ROT_MOD_EN: rotates load count = amt mod WIDTH.
module shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] OP_ROR = 3'b000;
  localparam logic [2:0] OP_ROL = 3'b001;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_SLL = 3'b011;
  localparam logic [2:0] OP_SRA = 3'b100;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] r_reg, r_next, r_step;
  logic [AMT_W-1:0] count_reg, count_next, load_amt;
  logic [2:0]       op_reg, op_next;
  logic             ovf_reg, ovf_next;
  logic             err_reg, err_next;
  logic             op_legal;

  assign op_legal = (op <= OP_SRA);

  always_comb begin
    load_amt = amt;
`ifdef SHSEQ_ROT_MOD_EN
    // A full rotation is the identity, so only the residue needs stepping.
    if (op == OP_ROR || op == OP_ROL) begin
      load_amt = amt & AMT_W'(WIDTH - 1);
    end
`endif
  end

  always_comb begin
    case (op_reg)
      OP_ROR:  r_step = {r_reg[0], r_reg[WIDTH-1:1]};
      OP_ROL:  r_step = {r_reg[WIDTH-2:0], r_reg[WIDTH-1]};
      OP_SRL:  r_step = {1'b0, r_reg[WIDTH-1:1]};
      OP_SLL:  r_step = {r_reg[WIDTH-2:0], 1'b0};
      OP_SRA:  r_step = {r_reg[WIDTH-1], r_reg[WIDTH-1:1]};
      default: r_step = r_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      r_reg     <= '0;
      count_reg <= '0;
      op_reg    <= '0;
      ovf_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      r_reg     <= r_next;
      count_reg <= count_next;
      op_reg    <= op_next;
      ovf_reg   <= ovf_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    r_next     = r_reg;
    count_next = count_reg;
    op_next    = op_reg;
    ovf_next   = ovf_reg;
    err_next   = err_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          r_next   = din;
          ovf_next = 1'b0;
          if (op_legal) begin
            op_next    = op;
            count_next = load_amt;
            err_next   = 1'b0;
            state_next = (load_amt != '0) ? SHIFT : DONE;
          end else begin
            count_next = '0;
            err_next   = 1'b1;
            state_next = DONE;
          end
        end
      end
      SHIFT: begin
        if (abort) begin
          state_next = IDLE;
        end else begin
          r_next = r_step;
          if (op_reg == OP_SLL && r_reg[WIDTH-1]) begin
            ovf_next = 1'b1;
          end
          // Guarded decrement keeps count from wrapping.
          if (count_reg != '0) begin
            count_next = count_reg - AMT_W'(1);
          end
          if (count_reg <= AMT_W'(1)) begin
            state_next = DONE;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign dout = r_reg;
  assign busy = (state_reg != IDLE);
  assign done = (state_reg == DONE);
  assign ovf  = ovf_reg;
  assign err  = err_reg;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: per-cycle trajectory model plus directed transactions.
module tb_shift_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] op = '0;
  logic [3:0] din = '0;
  logic [2:0] amt = '0;
  logic [3:0] dout;
  logic       busy, done, ovf, err;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;

  // Model: on acceptance the whole result trajectory is precomputed.
  int  m_vals [0:8];
  bit  m_ovfs [0:8];
  int  m_n = 0;
  int  m_e = 0;
  bit  m_busy = 1'b0;
  int  m_dout = 0;
  bit  m_ovf = 1'b0;
  bit  m_err = 1'b0;

  shift_sequencer #(.WIDTH(4), .AMT_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .op(op),
    .din(din), .amt(amt), .dout(dout), .busy(busy), .done(done),
    .ovf(ovf), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int step_val(input int o, input int r);
    case (o)
      0: return ((r >> 1) | (r << 3)) & 15;
      1: return ((r << 1) | (r >> 3)) & 15;
      2: return r >> 1;
      3: return (r << 1) & 15;
      default: return (r >> 1) | (r & 8);
    endcase
  endfunction

  function automatic int steps_for(input int o, input int a);
    if (o > 4) return 0;
`ifdef SHSEQ_ROT_MOD_EN
    if (o <= 1) return a % 4;
`endif
    return a;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      check("rst_dout", dout, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ovf", ovf, 0);
      check("rst_err", err, 0);
      m_busy = 0; m_dout = 0; m_ovf = 0; m_err = 0;
    end else begin
      if (m_busy) begin
        check("cyc_dout", dout, m_vals[m_e]);
        check("cyc_ovf", ovf, m_ovfs[m_e]);
        check("cyc_busy", busy, 1);
        check("cyc_done", done, m_e == m_n);
      end else begin
        check("cyc_dout", dout, m_dout);
        check("cyc_ovf", ovf, m_ovf);
        check("cyc_busy", busy, 0);
        check("cyc_done", done, 0);
      end
      check("cyc_err", err, m_err);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (!m_busy) begin
        if (start) begin
          m_busy = 1; m_e = 0;
          m_err = (op > 4);
          m_n = steps_for(int'(op), int'(amt));
          m_vals[0] = int'(din);
          m_ovfs[0] = 0;
          for (int i = 1; i <= m_n; i++) begin
            m_vals[i] = step_val(int'(op), m_vals[i-1]);
            m_ovfs[i] = m_ovfs[i-1] | (op == 3 && m_vals[i-1] >= 8);
          end
        end
      end else if (m_e < m_n && abort) begin
        m_busy = 0; m_dout = m_vals[m_e]; m_ovf = m_ovfs[m_e];
      end else if (m_e == m_n) begin
        m_busy = 0; m_dout = m_vals[m_n]; m_ovf = m_ovfs[m_n];
      end else begin
        m_e++;
      end
    end
  end

  // Latency counted from the edge after which start is raised to the edge that opens the done cycle.
  task automatic run(input string nm, input logic [2:0] o, input logic [3:0] d, input logic [2:0] a,
                     input logic [3:0] xd, input logic xo, input logic xe, input int xl, input bit poke);
    int k, c0;
    @(posedge clk); #1;
    op = o; din = d; amt = a; start = 1'b1;
    k = cyc; c0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 20 && done_cnt == c0; i++) begin
      @(posedge clk); #1;
      start = poke && (i == 1);
      if (start) begin
        op = 3'b000; din = 4'hF; amt = 3'd1;
      end
    end
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check({nm, "_dout"}, dout, xd);
    check({nm, "_ovf"}, ovf, xo);
    check({nm, "_err"}, err, xe);
    check({nm, "_ndone"}, done_cnt - c0, 1);
    check({nm, "_lat"}, done_cyc - k, xl);
    $display("txn %s op=%b din=%b amt=%0d -> dout=%b ovf=%b err=%b lat=%0d", nm, o, d, a, dout, ovf, err, done_cyc - k);
  endtask

  initial begin
    int c0;
    int rot_lat5, rot_lat4;
`ifdef SHSEQ_ROT_MOD_EN
    rot_lat5 = 2; rot_lat4 = 1;
`else
    rot_lat5 = 6; rot_lat4 = 5;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    // Asynchronous reset mid-SHIFT after two SLL steps.
    #1 op = 3'b011; din = 4'b1011; amt = 3'd5; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_dout", dout, 4'b1100);
    check("pre_rst_ovf", ovf, 1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_dout", dout, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_done", done, 0);
    check("async_rst_ovf", ovf, 0);
    $display("txn reset_mid_shift -> dout=%b busy=%b ovf=%b", dout, busy, ovf);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;

    run("sll",      3'b011, 4'b0110, 3'd2, 4'b1000, 1, 0, 3, 0);
    run("sra",      3'b100, 4'b1001, 3'd3, 4'b1111, 0, 0, 4, 0);
    run("srl",      3'b010, 4'b1001, 3'd3, 4'b0001, 0, 0, 4, 0);
    run("rol5",     3'b001, 4'b1000, 3'd5, 4'b0001, 0, 0, rot_lat5, 0);
    run("ror0",     3'b000, 4'b0011, 3'd0, 4'b0011, 0, 0, 1, 0);
    run("ror5",     3'b000, 4'b0011, 3'd5, 4'b1001, 0, 0, rot_lat5, 0);
    run("ror4",     3'b000, 4'b0110, 3'd4, 4'b0110, 0, 0, rot_lat4, 0);
    run("illegal",  3'b110, 4'b0101, 3'd3, 4'b0101, 0, 1, 1, 0);
    run("sll7_ign", 3'b011, 4'b0001, 3'd7, 4'b0000, 1, 0, 8, 1);

    // Abort after two steps of SLL 0001 by 4.
    @(posedge clk); #1;
    op = 3'b011; din = 4'b0001; amt = 3'd4; start = 1'b1;
    c0 = done_cnt;
    @(posedge clk); #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_dout", dout, 4'b0100);
    repeat (3) @(posedge clk);
    #1;
    check("abort_nodone", done_cnt - c0, 0);
    check("abort_hold", dout, 4'b0100);
    $display("txn abort sll din=0001 amt=4 -> dout=%b busy=%b", dout, busy);

    run("post_abort", 3'b000, 4'b0001, 3'd1, 4'b1000, 0, 0, 2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
